// File: rtl/kernel_dispatcher_pkg.sv
// Shared types for the kernel dispatcher: launch descriptor, top-level and per-core slot states.
package kernel_dispatcher_pkg;

    typedef logic [7:0] data_t;

    typedef struct packed {
        data_t base_instr_addr;
        data_t base_data_addr;
        data_t threads_per_block;
        data_t num_blocks;
    } kernel_config_t;

    typedef enum logic {
        K_IDLE,
        K_RUN
    } dispatch_state_t;

    typedef enum logic [1:0] {
        C_RST,
        C_IDLE,
        C_RUN
    } core_slot_state_t;

endpackage

// File: rtl/kernel_dispatcher_queue.sv
// Synchronous FIFO of kernel launch descriptors; push is dropped while full, pop is dropped while empty.
module kernel_queue
    import kernel_dispatcher_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push_i,
    input  kernel_config_t push_data_i,
    input  logic           pop_i,
    output kernel_config_t head_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [DEPTH-1:0] count_t;
    localparam count_t FULL_CNT = count_t'(DEPTH);

    kernel_config_t   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    count_t           count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + count_t'(1);
                2'b01:   count_q <= count_q - count_t'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/kernel_dispatcher.sv
// Queued kernel dispatcher: runs launches back to back, handing blocks to idle cores lowest-index first.
module kernel_dispatcher
    import kernel_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 2,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   kernel_valid,
    output logic                   kernel_ready,
    input  kernel_config_t         kernel_config,
    output kernel_config_t         active_config,
    output logic [NUM_CORES-1:0]   core_start,
    output logic [NUM_CORES-1:0]   core_reset,
    output data_t                  core_block_id [NUM_CORES],
    input  logic [NUM_CORES-1:0]   core_done,
    output logic                   busy,
    output logic                   kernel_done,
    output logic [COUNT_WIDTH-1:0] kernels_completed
);

    dispatch_state_t        state_q, state_d;
    kernel_config_t         active_q, active_d;
    data_t                  dispatched_q, dispatched_d;
    data_t                  completed_q, completed_d;
    logic [COUNT_WIDTH-1:0] kcount_q, kcount_d;
    core_slot_state_t       slot_q [NUM_CORES];
    core_slot_state_t       slot_d [NUM_CORES];
    data_t                  block_id_q [NUM_CORES];
    data_t                  block_id_d [NUM_CORES];

    logic                   q_pop;
    logic                   q_full;
    logic                   q_empty;
    kernel_config_t         q_head;

    logic                   can_assign;
    logic                   granted;
    logic [NUM_CORES-1:0]   grant;
    data_t                  done_sum;

    kernel_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push_i     (kernel_valid),
        .push_data_i(kernel_config),
        .pop_i      (q_pop),
        .head_o     (q_head),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= K_IDLE;
            active_q     <= '0;
            dispatched_q <= '0;
            completed_q  <= '0;
            kcount_q     <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                slot_q[i]     <= C_RST;
                block_id_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            dispatched_q <= dispatched_d;
            completed_q  <= completed_d;
            kcount_q     <= kcount_d;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                slot_q[i]     <= slot_d[i];
                block_id_q[i] <= block_id_d[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        dispatched_d = dispatched_q;
        completed_d  = completed_q;
        kcount_d     = kcount_q;
        q_pop        = 1'b0;
        kernel_done  = 1'b0;
        grant        = '0;
        granted      = 1'b0;
        done_sum     = '0;
        can_assign   = (state_q == K_RUN) && (dispatched_q < active_q.num_blocks);

        // Priority encoder: first idle slot wins; every running slot's done is summed.
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            slot_d[i]     = slot_q[i];
            block_id_d[i] = block_id_q[i];
            if (slot_q[i] == C_RUN && core_done[i]) begin
                done_sum = done_sum + data_t'(1);
            end
            if (can_assign && !granted && slot_q[i] == C_IDLE) begin
                grant[i] = 1'b1;
                granted  = 1'b1;
            end
        end

        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            case (slot_q[i])
                C_RST:   slot_d[i] = C_IDLE;
                C_IDLE: begin
                    if (grant[i]) begin
                        slot_d[i]     = C_RUN;
                        block_id_d[i] = dispatched_q;
                    end
                end
                C_RUN: begin
                    if (core_done[i]) begin
                        slot_d[i] = C_RST;
                    end
                end
                default: slot_d[i] = C_RST;
            endcase
        end

        if (granted) begin
            dispatched_d = dispatched_q + data_t'(1);
        end

        case (state_q)
            K_IDLE: begin
                if (!q_empty) begin
                    q_pop        = 1'b1;
                    active_d     = q_head;
                    dispatched_d = '0;
                    completed_d  = '0;
                    state_d      = K_RUN;
                end
            end
            K_RUN: begin
                completed_d = completed_q + done_sum;
                if (completed_q == active_q.num_blocks) begin
                    kernel_done = 1'b1;
                    kcount_d    = kcount_q + COUNT_WIDTH'(1);
                    state_d     = K_IDLE;
                end
            end
            default: state_d = K_IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            core_start[i]    = (slot_q[i] == C_RUN);
            core_reset[i]    = (slot_q[i] == C_RST);
            core_block_id[i] = block_id_q[i];
        end
    end

    assign kernel_ready      = ~q_full;
    assign active_config     = active_q;
    assign kernels_completed = kcount_q;
    assign busy              = (state_q == K_RUN) | ~q_empty;

endmodule
